laby5_sweep_ctrl: RTL and testbench

Sequencer that sits directly upstream of the Laby5 routing stage and exhaustively exercises it in hardware. On a start request it drives all eight `{a, b, vin}` input codes in ascending order, holding each code for a fixed number of cycles. It samples the stage's two outputs on the last cycle of each code and packs the results into two 8-bit response maps. This gives a self-checking on-board sweep, replacing manual switch stepping.

---
 rtl/laby5_sweep_ctrl.sv | 78 +++++++
 tb/tb_laby5_sweep_ctrl.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/laby5_sweep_ctrl.sv
// laby5_sweep_ctrl: walks all eight {a,b,vin} codes into the Laby5 stage and
// captures its o_vout/o_d responses into per-code 8-bit maps.
module laby5_sweep_ctrl #(
    parameter int DWELL = 4
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_start,
    input  logic       i_abort,
    input  logic       i_vout,
    input  logic       i_d,
    output logic       o_vin,
    output logic       o_b,
    output logic       o_a,
    output logic       o_busy,
    output logic       o_done,
    output logic [7:0] o_vout_map,
    output logic [7:0] o_d_map
);
    typedef enum logic [1:0] {IDLE, DRIVE, DONE} state_t;
    state_t     r_state;
    logic [2:0] r_k;
    logic [7:0] r_t;
    logic [2:0] r_drv;
    logic       w_last;
    assign w_last = (r_t == 8'(DWELL - 1));
    assign {o_a, o_b, o_vin} = r_drv;
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= IDLE;
            r_k        <= 3'd0;
            r_t        <= 8'd0;
            r_drv      <= 3'd0;
            o_busy     <= 1'b0;
            o_done     <= 1'b0;
            o_vout_map <= 8'h00;
            o_d_map    <= 8'h00;
        end else begin
            o_done <= 1'b0;
            case (r_state)
                IDLE: if (i_start && !i_abort) begin
                    r_state    <= DRIVE;
                    r_k        <= 3'd0;
                    r_t        <= 8'd0;
                    r_drv      <= 3'd0;
                    o_busy     <= 1'b1;
                    o_vout_map <= 8'h00;
                    o_d_map    <= 8'h00;
                end
                DRIVE: if (i_abort) begin
                    r_state <= IDLE;
                    r_k     <= 3'd0;
                    r_t     <= 8'd0;
                    r_drv   <= 3'd0;
                    o_busy  <= 1'b0;
                end else if (w_last) begin
                    // last dwell cycle: the stage has settled, capture its response
                    o_vout_map[r_k] <= i_vout;
                    o_d_map[r_k]    <= i_d;
                    r_t             <= 8'd0;
                    if (r_k == 3'd7) begin
                        r_state <= DONE;
                        r_k     <= 3'd0;
                        r_drv   <= 3'd0;
                        o_busy  <= 1'b0;
                        o_done  <= 1'b1;
                    end else begin
                        r_k   <= r_k + 3'd1;
                        r_drv <= r_k + 3'd1;
                    end
                end else begin
                    r_t <= r_t + 8'd1;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_laby5_sweep_ctrl.sv
// tb_laby5_sweep_ctrl: randomized sweeps of two instances (DWELL=4 and DWELL=1)
// against per-code response tables, with a done-triggered scoreboard.
module tb_laby5_sweep_ctrl;
    logic clk = 0, rst_n = 0;
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;
    int errors = 0, checks = 0;

    logic s4 = 0, ab4 = 0, vo4, dd4, vin4, b4, a4, busy4, done4;
    logic [7:0] vm4, dm4, lv4 = 0, ld4 = 0;
    logic s1 = 0, ab1 = 0, vo1, dd1, vin1, b1, a1, busy1, done1;
    logic [7:0] vm1, dm1, lv1 = 0, ld1 = 0;

    // downstream stage stand-ins: arbitrary truth tables indexed by the driven code
    assign vo4 = lv4[{a4, b4, vin4}];
    assign dd4 = ld4[{a4, b4, vin4}];
    assign vo1 = lv1[{a1, b1, vin1}];
    assign dd1 = ld1[{a1, b1, vin1}];

    laby5_sweep_ctrl #(.DWELL(4)) u4 (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(s4), .i_abort(ab4), .i_vout(vo4), .i_d(dd4),
        .o_vin(vin4), .o_b(b4), .o_a(a4), .o_busy(busy4), .o_done(done4),
        .o_vout_map(vm4), .o_d_map(dm4));
    laby5_sweep_ctrl #(.DWELL(1)) u1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(s1), .i_abort(ab1), .i_vout(vo1), .i_d(dd1),
        .o_vin(vin1), .o_b(b1), .o_a(a1), .o_busy(busy1), .o_done(done1),
        .o_vout_map(vm1), .o_d_map(dm1));

    typedef struct {logic [7:0] v; logic [7:0] d; int at;} exp_t;
    exp_t q4[$], q1[$];
    exp_t e4, e1;

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", n, act, exp, cyc);
        end
    endtask

    // monitor: every o_done pulse must match the oldest queued expectation
    initial forever begin
        @(posedge clk);
        #1;
        if (done4) begin
            if (q4.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL u4 unexpected done at cycle %0d", cyc);
            end else begin
                e4 = q4.pop_front();
                chk("u4 vout_map", vm4, e4.v);
                chk("u4 d_map", dm4, e4.d);
                chk("u4 done cycle", cyc, e4.at);
                chk("u4 busy at done", busy4, 0);
            end
        end
        if (done1) begin
            if (q1.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL u1 unexpected done at cycle %0d", cyc);
            end else begin
                e1 = q1.pop_front();
                chk("u1 vout_map", vm1, e1.v);
                chk("u1 d_map", dm1, e1.d);
                chk("u1 done cycle", cyc, e1.at);
            end
        end
    end

    task automatic run4(input logic [7:0] v, d, input int restart_at, abort_at, rst_at);
        int stop;
        logic [7:0] mask;
        stop = (abort_at != 0) ? abort_at : (rst_at != 0) ? rst_at : 32;
        mask = 8'h00;
        for (int k = 0; k < 8; k++) if ((k + 1) * 4 < stop) mask[k] = 1'b1;
        @(negedge clk);
        lv4 = v;
        ld4 = d;
        s4 = 1;
        for (int i = 1; i <= stop; i++) begin
            @(posedge clk);
            #1;
            if (i == 1) begin
                chk("u4 map clear", {vm4, dm4}, 16'h0);
                if (stop == 32) q4.push_back('{v, d, cyc + 32});
            end
            chk("u4 busy", busy4, 1);
            chk("u4 code", {a4, b4, vin4}, (i - 1) / 4);
            if (i == rst_at) begin
                #2;
                rst_n = 0;
                #1;
            end else begin
                @(negedge clk);
                s4 = (i == restart_at);
                ab4 = (i == abort_at);
            end
        end
        if (abort_at != 0) begin
            @(posedge clk);
            #1;
            chk("u4 abort idle", {busy4, done4, a4, b4, vin4}, 0);
            chk("u4 abort vout_map", vm4, v & mask);
            chk("u4 abort d_map", dm4, d & mask);
            @(negedge clk);
            ab4 = 0;
        end else if (rst_at != 0) begin
            chk("u4 reset outputs", {busy4, done4, a4, b4, vin4}, 0);
            chk("u4 reset maps", {vm4, dm4}, 16'h0);
            @(negedge clk);
            rst_n = 1;
        end else begin
            repeat (4) @(posedge clk);
            #1;
            chk("u4 idle after sweep", busy4, 0);
            chk("u4 done pending", q4.size(), 0);
        end
    endtask

    task automatic run1(input logic [7:0] v, d);
        @(negedge clk);
        lv1 = v;
        ld1 = d;
        s1 = 1;
        for (int i = 1; i <= 8; i++) begin
            @(posedge clk);
            #1;
            if (i == 1) begin
                chk("u1 map clear", {vm1, dm1}, 16'h0);
                q1.push_back('{v, d, cyc + 8});
            end
            chk("u1 busy", busy1, 1);
            chk("u1 code", {a1, b1, vin1}, i - 1);
            @(negedge clk);
            s1 = 0;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    logic [7:0] fv, fd;
    int ab;

    initial begin
        #12;
        chk("reset u4 outputs", {busy4, done4, a4, b4, vin4, vm4, dm4}, 0);
        chk("reset u1 outputs", {busy1, done1, a1, b1, vin1, vm1, dm1}, 0);
        @(negedge clk);
        rst_n = 1;
        @(posedge clk);
        #1;
        chk("idle after reset", busy4, 0);
        for (int k = 0; k < 8; k++) begin
            fv[k] = (k & 1) != 0 && (k & 2) == 0 && (k & 4) == 0;
            fd[k] = (k & 1) != 0 && (k & 2) != 0 && (k & 4) != 0;
        end
        run4(fv, fd, 0, 0, 0);
        run4(8'hAA, 8'($urandom), 0, 14, 0);
        run4(8'($urandom), 8'($urandom), 10, 0, 0);
        @(negedge clk);
        s4 = 1;
        ab4 = 1;
        @(posedge clk);
        #1;
        chk("start+abort idle", {busy4, a4, b4, vin4}, 0);
        @(negedge clk);
        s4 = 0;
        ab4 = 0;
        run4(8'($urandom), 8'($urandom), 0, 0, 22);
        run4(8'($urandom), 8'($urandom), 0, 0, 0);
        for (int n = 0; n < 3; n++) begin
            ab = $urandom_range(1, 31);
            if (ab % 4 == 0) ab++;
            run4(8'($urandom), 8'($urandom), 0, ab, 0);
            run4(8'($urandom), 8'($urandom), $urandom_range(1, 31), 0, 0);
        end
        run1(8'hFF, 8'h00);
        run1(8'($urandom), 8'($urandom));
        run1(8'($urandom), 8'($urandom));
        repeat (3) @(posedge clk);
        #1;
        chk("u1 idle", busy1, 0);
        chk("u1 done pending", q1.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule
